// File: rtl/cpu_pkg.sv
// Shared 6502 datapath definitions: PC sequencer state encoding and the
// hardware vector addresses.
package cpu_pkg;

  typedef enum logic [1:0] {
    VEC_LO = 2'd0,
    VEC_HI = 2'd1,
    RUN    = 2'd2
  } pc_state_e;

  localparam logic [15:0] RESET_VEC = 16'hFFFC;
  localparam logic [15:0] NMI_VEC   = 16'hFFFA;
  localparam logic [15:0] IRQ_VEC   = 16'hFFFE;

endpackage

// File: rtl/pc_incrementer.sv
// Combinational PCL/PCH source select followed by the 16-bit increment;
// the low-byte carry ripples into whichever high byte was selected.
module pc_incrementer (
  input  logic       i_adl_load,
  input  logic       i_pcl_load,
  input  logic       i_adh_load,
  input  logic       i_pch_load,
  input  logic       i_inc,
  input  logic [7:0] i_adl_data,
  input  logic [7:0] i_adh_data,
  input  logic [7:0] i_pcl,
  input  logic [7:0] i_pch,
  output logic [7:0] o_lo,
  output logic [7:0] o_hi,
  output logic       o_carry
);

  logic [7:0] w_lo_sel;
  logic [7:0] w_hi_sel;
  logic       w_c;

  always_comb begin
    w_lo_sel = i_pcl;
    w_hi_sel = i_pch;
    // Loop path and "no load" pick the same register; the explicit branch
    // keeps the bus-over-loop priority visible.
    if (i_adl_load)      w_lo_sel = i_adl_data;
    else if (i_pcl_load) w_lo_sel = i_pcl;
    if (i_adh_load)      w_hi_sel = i_adh_data;
    else if (i_pch_load) w_hi_sel = i_pch;

    {w_c, o_lo} = {1'b0, w_lo_sel} + {8'd0, i_inc};
    o_hi        = w_hi_sel + {7'd0, w_c};
    o_carry     = w_c;
  end

endmodule

// File: rtl/pc_unit.sv
// 6502 program-counter stage: fetches the reset vector, then updates PC
// from the select/increment logic and drives PCL/PCH onto the buses.
module pc_unit
  import cpu_pkg::*;
#(
  parameter logic [15:0] VECTOR = RESET_VEC
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        ADL_LOAD,
  input  logic        PCL_LOAD,
  input  logic        ADH_LOAD,
  input  logic        PCH_LOAD,
  input  logic        INC,
  input  logic [7:0]  ADL_DATA,
  input  logic [7:0]  ADH_DATA,
  input  logic [7:0]  DB_IN,
  input  logic        PCL_DB_EN,
  input  logic        PCL_ADL_EN,
  input  logic        PCH_DB_EN,
  input  logic        PCH_ADH_EN,
  output logic [15:0] ADDR_OUT,
  output logic [7:0]  DB_OUT,
  output logic [7:0]  ADL_OUT,
  output logic [7:0]  ADH_OUT,
  output logic        CARRY_OUT,
  output logic        VEC_BUSY
);

  pc_state_e  r_state;
  pc_state_e  w_state_nxt;
  logic [7:0] r_pcl;
  logic [7:0] r_pch;
  logic       r_carry;
  logic [7:0] w_pcl_nxt;
  logic [7:0] w_pch_nxt;
  logic       w_carry_nxt;
  logic [15:0] w_addr;
  logic [7:0] w_inc_lo;
  logic [7:0] w_inc_hi;
  logic       w_inc_c;

  pc_incrementer u_inc (
    .i_adl_load (ADL_LOAD),
    .i_pcl_load (PCL_LOAD),
    .i_adh_load (ADH_LOAD),
    .i_pch_load (PCH_LOAD),
    .i_inc      (INC),
    .i_adl_data (ADL_DATA),
    .i_adh_data (ADH_DATA),
    .i_pcl      (r_pcl),
    .i_pch      (r_pch),
    .o_lo       (w_inc_lo),
    .o_hi       (w_inc_hi),
    .o_carry    (w_inc_c)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= VEC_LO;
      r_pcl   <= VECTOR[7:0];
      r_pch   <= VECTOR[15:8];
      r_carry <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pcl   <= w_pcl_nxt;
      r_pch   <= w_pch_nxt;
      r_carry <= w_carry_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pcl_nxt   = r_pcl;
    w_pch_nxt   = r_pch;
    w_carry_nxt = r_carry;
    w_addr      = {r_pch, r_pcl};
    case (r_state)
      VEC_LO: begin
        w_addr      = VECTOR;
        w_pcl_nxt   = DB_IN;
        w_state_nxt = VEC_HI;
      end
      VEC_HI: begin
        w_addr      = VECTOR + 16'd1;
        w_pch_nxt   = DB_IN;
        w_state_nxt = RUN;
      end
      RUN: begin
        w_pcl_nxt   = w_inc_lo;
        w_pch_nxt   = w_inc_hi;
        w_carry_nxt = w_inc_c;
      end
      default: begin
        w_addr      = VECTOR;
        w_state_nxt = VEC_LO;
      end
    endcase
  end

  assign ADDR_OUT  = w_addr;
  assign VEC_BUSY  = (r_state != RUN);
  assign CARRY_OUT = r_carry;
  assign DB_OUT    = (PCL_DB_EN ? r_pcl : '0) | (PCH_DB_EN ? r_pch : '0);
  assign ADL_OUT   = PCL_ADL_EN ? r_pcl : '0;
  assign ADH_OUT   = PCH_ADH_EN ? r_pch : '0;

  // Both PC bytes on DB at once is a decoder fault upstream.
  a_db_single_driver: assert property (
    @(posedge CLK) disable iff (!RST_N) !(PCL_DB_EN && PCH_DB_EN));

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: directed vector table, a behavioural
// PC model under random stimulus, and reset-fetch / mid-run reset sequences.
module tb_pc_unit;

  logic        CLK;
  logic        RST_N;
  logic        ADL_LOAD, PCL_LOAD, ADH_LOAD, PCH_LOAD, INC;
  logic [7:0]  ADL_DATA, ADH_DATA, DB_IN;
  logic        PCL_DB_EN, PCL_ADL_EN, PCH_DB_EN, PCH_ADH_EN;
  logic [15:0] ADDR_OUT;
  logic [7:0]  DB_OUT, ADL_OUT, ADH_OUT;
  logic        CARRY_OUT, VEC_BUSY;

  int n_cmp = 0;
  int n_err = 0;

  pc_unit #(.VECTOR(16'hFFFC)) dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .ADL_LOAD   (ADL_LOAD),
    .PCL_LOAD   (PCL_LOAD),
    .ADH_LOAD   (ADH_LOAD),
    .PCH_LOAD   (PCH_LOAD),
    .INC        (INC),
    .ADL_DATA   (ADL_DATA),
    .ADH_DATA   (ADH_DATA),
    .DB_IN      (DB_IN),
    .PCL_DB_EN  (PCL_DB_EN),
    .PCL_ADL_EN (PCL_ADL_EN),
    .PCH_DB_EN  (PCH_DB_EN),
    .PCH_ADH_EN (PCH_ADH_EN),
    .ADDR_OUT   (ADDR_OUT),
    .DB_OUT     (DB_OUT),
    .ADL_OUT    (ADL_OUT),
    .ADH_OUT    (ADH_OUT),
    .CARRY_OUT  (CARRY_OUT),
    .VEC_BUSY   (VEC_BUSY)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic        adl_load, pcl_load, adh_load, pch_load, inc;
    logic [7:0]  adl, adh;
    logic [15:0] exp_addr;
    logic        exp_carry;
  } vec_t;

  vec_t tbl[12];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_ctrl();
    ADL_LOAD = 0; PCL_LOAD = 0; ADH_LOAD = 0; PCH_LOAD = 0; INC = 0;
    ADL_DATA = '0; ADH_DATA = '0;
    PCL_DB_EN = 0; PCL_ADL_EN = 0; PCH_DB_EN = 0; PCH_ADH_EN = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] m_pc;
    logic        m_carry;
    int          lo_sum, sel_lo, sel_hi, full;
    int unsigned dbsel;

    // adl_load pcl_load adh_load pch_load inc adl adh exp_addr exp_carry
    tbl[0]  = '{0, 0, 0, 0, 1, 8'h00, 8'h00, 16'h1235, 1'b0};
    tbl[1]  = '{0, 0, 0, 0, 1, 8'h00, 8'h00, 16'h1236, 1'b0};
    tbl[2]  = '{0, 1, 0, 1, 1, 8'h00, 8'h00, 16'h1237, 1'b0};
    tbl[3]  = '{1, 0, 0, 0, 0, 8'hFF, 8'h00, 16'h12FF, 1'b0};
    tbl[4]  = '{0, 0, 0, 0, 1, 8'h00, 8'h00, 16'h1300, 1'b1};
    tbl[5]  = '{0, 0, 0, 0, 0, 8'h00, 8'h00, 16'h1300, 1'b0};
    tbl[6]  = '{1, 0, 1, 0, 0, 8'hFF, 8'hFF, 16'hFFFF, 1'b0};
    tbl[7]  = '{0, 0, 0, 0, 1, 8'h00, 8'h00, 16'h0000, 1'b1};
    tbl[8]  = '{1, 0, 1, 0, 1, 8'hFF, 8'h55, 16'h5600, 1'b1};
    tbl[9]  = '{0, 0, 1, 1, 0, 8'h00, 8'h21, 16'h2100, 1'b0};
    tbl[10] = '{1, 1, 1, 0, 1, 8'h40, 8'h80, 16'h8041, 1'b0};
    tbl[11] = '{0, 1, 0, 1, 0, 8'h00, 8'h00, 16'h8041, 1'b0};

    clear_ctrl();
    DB_IN = 8'h00;
    RST_N = 1'b0;
    #1;
    check("reset addr", ADDR_OUT, 16'hFFFC);
    check("reset busy", 16'(VEC_BUSY), 16'd1);
    check("reset carry", 16'(CARRY_OUT), 16'd0);
    #2 RST_N = 1'b1;

    DB_IN = 8'h34;
    step();
    check("fetch hi addr", ADDR_OUT, 16'hFFFD);
    check("fetch hi busy", 16'(VEC_BUSY), 16'd1);
    DB_IN = 8'h12;
    step();
    check("fetch run addr", ADDR_OUT, 16'h1234);
    check("fetch run busy", 16'(VEC_BUSY), 16'd0);
    check("fetch run carry", 16'(CARRY_OUT), 16'd0);

    for (int i = 0; i < 12; i++) begin
      ADL_LOAD = tbl[i].adl_load; PCL_LOAD = tbl[i].pcl_load;
      ADH_LOAD = tbl[i].adh_load; PCH_LOAD = tbl[i].pch_load;
      INC = tbl[i].inc; ADL_DATA = tbl[i].adl; ADH_DATA = tbl[i].adh;
      step();
      check($sformatf("vec%0d addr", i), ADDR_OUT, tbl[i].exp_addr);
      check($sformatf("vec%0d carry", i), 16'(CARRY_OUT), 16'(tbl[i].exp_carry));
    end
    clear_ctrl();

    PCL_ADL_EN = 1; PCH_ADH_EN = 1;
    #1;
    check("bus adl", 16'(ADL_OUT), 16'h0041);
    check("bus adh", 16'(ADH_OUT), 16'h0080);
    check("bus db idle", 16'(DB_OUT), 16'h0000);
    PCL_ADL_EN = 0; PCH_ADH_EN = 0; PCL_DB_EN = 1;
    #1;
    check("bus db pcl", 16'(DB_OUT), 16'h0041);
    check("bus adl idle", 16'(ADL_OUT), 16'h0000);
    PCL_DB_EN = 0; PCH_DB_EN = 1;
    #1;
    check("bus db pch", 16'(DB_OUT), 16'h0080);
    PCH_DB_EN = 0;

    m_pc = 16'h8041;
    m_carry = 1'b0;
    for (int n = 0; n < 300; n++) begin
      ADL_LOAD = 1'($urandom); PCL_LOAD = 1'($urandom);
      ADH_LOAD = 1'($urandom); PCH_LOAD = 1'($urandom);
      INC = ($urandom_range(3) != 0);
      ADL_DATA = ($urandom_range(3) == 0) ? 8'hFF : 8'($urandom);
      ADH_DATA = 8'($urandom);
      dbsel = $urandom_range(2);
      PCL_DB_EN = (dbsel == 1); PCH_DB_EN = (dbsel == 2);
      PCL_ADL_EN = 1'($urandom); PCH_ADH_EN = 1'($urandom);
      #1;
      check("rnd db", 16'(DB_OUT),
            16'(dbsel == 1 ? m_pc[7:0] : dbsel == 2 ? m_pc[15:8] : 8'h00));
      check("rnd adl", 16'(ADL_OUT), 16'(PCL_ADL_EN ? m_pc[7:0] : 8'h00));
      check("rnd adh", 16'(ADH_OUT), 16'(PCH_ADH_EN ? m_pc[15:8] : 8'h00));
      sel_lo = ADL_LOAD ? int'(ADL_DATA) : int'(m_pc[7:0]);
      sel_hi = ADH_LOAD ? int'(ADH_DATA) : int'(m_pc[15:8]);
      lo_sum = sel_lo + int'(INC);
      full   = sel_hi * 256 + lo_sum;
      m_pc    = 16'(full % 65536);
      m_carry = (lo_sum > 255);
      step();
      check("rnd addr", ADDR_OUT, m_pc);
      check("rnd carry", 16'(CARRY_OUT), 16'(m_carry));
      check("rnd busy", 16'(VEC_BUSY), 16'd0);
    end
    clear_ctrl();

    ADL_LOAD = 1; ADL_DATA = 8'hFF; ADH_LOAD = 1; ADH_DATA = 8'h80; INC = 1;
    step();
    check("pre-reset addr", ADDR_OUT, 16'h8100);
    check("pre-reset carry", 16'(CARRY_OUT), 16'd1);
    clear_ctrl();

    RST_N = 1'b0;
    #1;
    check("midrun reset addr", ADDR_OUT, 16'hFFFC);
    check("midrun reset carry", 16'(CARRY_OUT), 16'd0);
    check("midrun reset busy", 16'(VEC_BUSY), 16'd1);
    PCL_DB_EN = 1;
    #1;
    check("fetch db pcl", 16'(DB_OUT), 16'h00FC);
    PCL_DB_EN = 0;
    #1 RST_N = 1'b1;

    // loads and INC must be ignored while the vector is being fetched
    ADL_LOAD = 1; ADL_DATA = 8'h11; ADH_LOAD = 1; ADH_DATA = 8'h22; INC = 1;
    DB_IN = 8'hAB;
    step();
    check("refetch hi addr", ADDR_OUT, 16'hFFFD);
    check("refetch hi carry", 16'(CARRY_OUT), 16'd0);
    PCL_ADL_EN = 1; PCH_ADH_EN = 1;
    #1;
    check("partial adl", 16'(ADL_OUT), 16'h00AB);
    check("partial adh", 16'(ADH_OUT), 16'h00FF);
    DB_IN = 8'hCD;
    step();
    check("refetch run addr", ADDR_OUT, 16'hCDAB);
    check("refetch run busy", 16'(VEC_BUSY), 16'd0);
    check("refetch run carry", 16'(CARRY_OUT), 16'd0);
    clear_ctrl();
    step();
    check("hold addr", ADDR_OUT, 16'hCDAB);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
- Program-counter stage for the 6502 datapath. Holds the 16-bit PC (PCL/PCH) and includes the PCL/PCH select logic and the increment logic.
- Produces the "Increment logic" data that feeds the low-byte PC register and its loop path.
- Drives PCL onto DB/ADL and PCH onto DB/ADH.
- Performs the reset-vector fetch sequence itself before handing control to the decoder.

Parameters:
- VECTOR, 16'hFFFC, address of the reset-vector low byte; the high byte is read from VECTOR+1.

Ports:
- CLK  input  1  system clock; all state updates on the rising edge.
- RST_N  input  1  asynchronous active-low reset.
- ADL_LOAD  input  1  select ADL_DATA as the next PCL source.
- PCL_LOAD  input  1  select the current PCL (loop path) as the next PCL source.
- ADH_LOAD  input  1  select ADH_DATA as the next PCH source.
- PCH_LOAD  input  1  select the current PCH as the next PCH source.
- INC  input  1  add 1 to the selected 16-bit value.
- ADL_DATA  input  8  ADL bus value.
- ADH_DATA  input  8  ADH bus value.
- DB_IN  input  8  data bus; carries the vector bytes during the fetch.
- PCL_DB_EN  input  1  drive PCL onto DB_OUT.
- PCL_ADL_EN  input  1  drive PCL onto ADL_OUT.
- PCH_DB_EN  input  1  drive PCH onto DB_OUT.
- PCH_ADH_EN  input  1  drive PCH onto ADH_OUT.
- ADDR_OUT  output  16  fetch address.
- DB_OUT  output  8  data-bus drive.
- ADL_OUT  output  8  ADL-bus drive.
- ADH_OUT  output  8  ADH-bus drive.
- CARRY_OUT  output  1  registered; the last update carried from PCL into PCH.
- VEC_BUSY  output  1  high while the vector fetch is in progress.

Behaviour:
- Clocking: one clock (CLK); reset is asynchronous and active-low (RST_N).
- Reset (RST_N=0): state=VEC_LO, PC=VECTOR, CARRY_OUT=0, VEC_BUSY=1. Takes effect immediately and is independent of CLK. An assertion mid-sequence or mid-run aborts everything.
- FSM states: VEC_LO, VEC_HI, RUN.
- VEC_LO:
  - ADDR_OUT=VECTOR.
  - On the edge: PCL<=DB_IN, go to VEC_HI.
- VEC_HI:
  - ADDR_OUT=VECTOR+1.
  - On the edge: PCH<=DB_IN, go to RUN; VEC_BUSY falls in the same edge.
- RUN: ADDR_OUT={PCH,PCL}; VEC_BUSY=0.
- Control inputs during fetch: in VEC_LO and VEC_HI, all load/INC inputs are ignored. Bus enables still work and drive the partially loaded PC.
- Low-byte select: lo = ADL_LOAD ? ADL_DATA : PCL. ADL_LOAD takes priority over PCL_LOAD. Neither asserted selects PCL.
- High-byte select: hi = ADH_LOAD ? ADH_DATA : PCH, with the same priority rule.
- Increment: {c,lo'} = lo + INC (9-bit); hi' = hi + c, modulo 256.
  - 16'hFFFF + 1 wraps to 16'h0000 with CARRY_OUT=1.
- Every RUN edge: PCL<=lo', PCH<=hi', CARRY_OUT<=c.
  - With no loads and INC=0, the PC holds and CARRY_OUT clears to 0.
- Latency: one cycle from control input to the new PC on ADDR_OUT. Bus outputs reflect the registered PC combinationally.
- Bus drive: each output bus is 8'h00 when none of its enables are asserted; the top level ORs the buses together.
  - DB_OUT = (PCL_DB_EN ? PCL : 0) | (PCH_DB_EN ? PCH : 0).
  - Asserting both DB enables is a decoder error. The OR result is defined behaviour and is checked by an assertion only.
- Simultaneous ADL_LOAD and INC: the jump target plus one (branch/JSR style).
- Simultaneous ADH_LOAD and a low-byte carry: the carry is added to ADH_DATA.

Decomposition:
- Shared package cpu_pkg holds:
  - the FSM state encoding (VEC_LO=2'd0, VEC_HI=2'd1, RUN=2'd2);
  - the vector constants RESET_VEC=16'hFFFC, NMI_VEC=16'hFFFA, IRQ_VEC=16'hFFFE.
- One sub-module, pc_incrementer: purely combinational 16-bit select plus increment producing {hi',lo',c}. It is reused by the top-level address adder checks.

Test Plan:
- Reset fetch: hold RST_N=0, release. DB_IN=8'h34 in VEC_LO, 8'h12 in VEC_HI.
  - ADDR_OUT sequence FFFC, FFFD, then 1234.
  - VEC_BUSY goes 1,1,0.
- Linear increment: PC=1234, INC=1 for 3 cycles.
  - ADDR_OUT 1235, 1236, 1237; CARRY_OUT stays 0.
- Page cross: PC=12FF, INC=1.
  - PC=1300, CARRY_OUT=1; the next idle cycle gives CARRY_OUT=0.
- Wrap: PC=FFFF, INC=1.
  - PC=0000, CARRY_OUT=1.
- Jump+1: ADL_LOAD=1, ADL_DATA=40, ADH_LOAD=1, ADH_DATA=80, INC=1, with PCL_LOAD also set.
  - PC=8041, confirming that ADL wins.
- Reset mid-run plus bus drive:
  - With PC=8041, PCL_ADL_EN=1 and PCH_ADH_EN=1 give ADL_OUT=41, ADH_OUT=80, DB_OUT=00.
  - Pulse RST_N low between edges: ADDR_OUT=FFFC immediately and CARRY_OUT=0.
